// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry controller: key values,
// state encodings for the debounce and entry state machines, and a
// key classification helper.
package keypad_pkg;

  // Function keys on the 4x4 pad; 0x0-0x9 are digits, 0xC-0xF are unused
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  // Debounce FSM: released, press-debounce, held, release-debounce
  typedef enum logic [1:0] {
    REL  = 2'd0,
    PDEB = 2'd1,
    HELD = 2'd2,
    RDEB = 2'd3
  } db_state_t;

  // Entry FSM: no digits, partial/complete digits, waiting for consumer
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTER = 2'd1,
    READY = 2'd2
  } entry_state_t;

  // True for the ten decimal digit keys
  function automatic logic is_digit(input logic [3:0] key);
    return (key <= 4'h9);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces the raw keypad level and produces exactly one single-cycle
// key_evt per physical press. The code seen at the start of a press is
// latched; a drop or a code change during press debounce restarts the
// press. Release must be stable for DEBOUNCE_CYCLES before a new press
// can be recognised, so bounces on release never repeat the key.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_down,
  input  logic [3:0] key_code,
  output logic       key_evt,
  output logic [3:0] key_val
);

  // Counter just wide enough to reach DEBOUNCE_CYCLES-1
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  db_state_t     state_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    latch_reg;
  logic          key_evt_reg;

  assign key_evt = key_evt_reg;
  assign key_val = latch_reg;

  // Debounce state machine with registered event pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= REL;
      cnt_reg     <= '0;
      latch_reg   <= 4'h0;
      key_evt_reg <= 1'b0;
    end else begin
      key_evt_reg <= 1'b0;
      case (state_reg)
        REL: begin
          if (key_down) begin
            state_reg <= PDEB;
            cnt_reg   <= '0;
            latch_reg <= key_code;
          end
        end
        PDEB: begin
          if (key_down && (key_code == latch_reg)) begin
            if (cnt_reg == CNT_LAST) begin
              state_reg   <= HELD;
              key_evt_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            // Bounce or a different key: start over from released
            state_reg <= REL;
          end
        end
        HELD: begin
          if (!key_down) begin
            state_reg <= RDEB;
            cnt_reg   <= '0;
          end
        end
        RDEB: begin
          if (key_down) begin
            // Release bounce: still the same press, no new event
            state_reg <= HELD;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= REL;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= REL;
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: debounces scanner output, collects BCD digits
// with ENTER/CLEAR editing and offers the finished item code on a
// valid/ready handshake.
// Optional feature: define KEYPAD_TIMEOUT_EN to discard a partial entry
// after TIMEOUT_CYCLES cycles without a key event.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int DIGITS          = 2,
  parameter int TIMEOUT_CYCLES  = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_down,
  input  logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   code,
  output logic                  code_valid,
  input  logic                  code_ready,
  output logic [2:0]            digit_cnt,
  output logic                  entry_err
);

  // Elaboration-time parameter sanity checks
  generate
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
      $error("keypad_entry_ctrl: DIGITS must be in 1..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("keypad_entry_ctrl: DEBOUNCE_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("keypad_entry_ctrl: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  localparam logic [2:0] DIGITS_MAX = 3'(DIGITS);

  logic                 key_evt;
  logic [3:0]           key_val;

  entry_state_t         state_reg;
  logic [4*DIGITS-1:0]  code_reg;
  logic                 code_valid_reg;
  logic [2:0]           digit_cnt_reg;
  logic                 entry_err_reg;

  logic [4*DIGITS-1:0]  code_shift;
  logic                 entry_full;
  logic                 timeout;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .key_down (key_down),
    .key_code (key_code),
    .key_evt  (key_evt),
    .key_val  (key_val)
  );

  // New digit enters at the bottom; older digits move up one position
  // and the oldest falls off the top. Written per digit so DIGITS=1 works.
  assign code_shift[3:0] = key_val;
  genvar gi;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_shift
      assign code_shift[4*gi +: 4] = code_reg[4*(gi-1) +: 4];
    end
  endgenerate

  assign entry_full = (digit_cnt_reg == DIGITS_MAX);

`ifdef KEYPAD_TIMEOUT_EN
  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] idle_cnt_reg;

  // A key event in the same cycle wins over the timeout
  assign timeout = (state_reg == ENTER) && !key_evt && (idle_cnt_reg == IDLE_LAST);

  // Idle counter: runs only while a partial entry is open
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt_reg <= 32'd0;
    end else if ((state_reg != ENTER) || key_evt || timeout) begin
      idle_cnt_reg <= 32'd0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 32'd1;
    end
  end
`else
  // Partial entries persist until CLEAR, completion or reset
  assign timeout = 1'b0;
`endif

  // Entry state machine: digit shift register, editing and handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= EMPTY;
      code_reg       <= '0;
      code_valid_reg <= 1'b0;
      digit_cnt_reg  <= 3'd0;
      entry_err_reg  <= 1'b0;
    end else begin
      entry_err_reg <= 1'b0;
      case (state_reg)
        EMPTY, ENTER: begin
          if (key_evt) begin
            if (is_digit(key_val)) begin
              if (entry_full) begin
                entry_err_reg <= 1'b1;
              end else begin
                code_reg      <= code_shift;
                digit_cnt_reg <= digit_cnt_reg + 3'd1;
                state_reg     <= ENTER;
              end
            end else if (key_val == KEY_ENTER) begin
              if (entry_full) begin
                state_reg      <= READY;
                code_valid_reg <= 1'b1;
              end else begin
                entry_err_reg <= 1'b1;
              end
            end else if (key_val == KEY_CLEAR) begin
              code_reg      <= '0;
              digit_cnt_reg <= 3'd0;
              state_reg     <= EMPTY;
            end
            // 0xC-0xF fall through: ignored without an error
          end else if (timeout) begin
            code_reg      <= '0;
            digit_cnt_reg <= 3'd0;
            state_reg     <= EMPTY;
            entry_err_reg <= 1'b1;
          end
        end
        READY: begin
          // Code is frozen here; only the consumer can release it
          if (code_ready) begin
            code_reg       <= '0;
            code_valid_reg <= 1'b0;
            digit_cnt_reg  <= 3'd0;
            state_reg      <= EMPTY;
          end
          // Keys are never queued behind a pending code
          if (key_evt) begin
            entry_err_reg <= 1'b1;
          end
        end
        default: begin
          state_reg      <= EMPTY;
          code_reg       <= '0;
          code_valid_reg <= 1'b0;
          digit_cnt_reg  <= 3'd0;
        end
      endcase
    end
  end

  assign code       = code_reg;
  assign code_valid = code_valid_reg;
  assign digit_cnt  = digit_cnt_reg;
  assign entry_err  = entry_err_reg;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl: directed scenarios plus a
// randomized key stream, checked by a scoreboard of expected error pulses
// and handshakes and by a reference model of the entry rules.
module tb_keypad_entry_ctrl;

  localparam int DEB = 4;
  localparam int DIG = 2;
  localparam int TMO = 100;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             key_down = 1'b0;
  logic [3:0]       key_code = 4'h0;
  logic             code_ready = 1'b0;
  logic [4*DIG-1:0] code;
  logic             code_valid;
  logic [2:0]       digit_cnt;
  logic             entry_err;

  always #5 clk = ~clk;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .DIGITS          (DIG),
    .TIMEOUT_CYCLES  (TMO)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .key_down   (key_down),
    .key_code   (key_code),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .digit_cnt  (digit_cnt),
    .entry_err  (entry_err)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: an error pulse or a handshake carrying a code
  typedef struct {
    bit         is_err;
    logic [7:0] code;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: the entered digits in order, and whether the entry
  // has been confirmed and waits for the consumer
  int mdl_digits[$];
  bit mdl_ready = 1'b0;

  function automatic logic [7:0] mdl_code();
    int v;
    v = 0;
    foreach (mdl_digits[i]) v = v * 16 + mdl_digits[i];
    return 8'(v);
  endfunction

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.code   = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic model_key(input int k);
    if (mdl_ready) begin
      push_err();
    end else if (k <= 9) begin
      if (mdl_digits.size() == DIG) push_err();
      else mdl_digits.push_back(k);
    end else if (k == 10) begin
      if (mdl_digits.size() == DIG) mdl_ready = 1'b1;
      else push_err();
    end else if (k == 11) begin
      mdl_digits.delete();
    end
  endtask

  task automatic model_handshake();
    exp_t e;
    e.is_err = 1'b0;
    e.code   = mdl_code();
    exp_q.push_back(e);
    mdl_digits.delete();
    mdl_ready = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic check_outputs(input string name);
    check({name, "_code"}, 32'(code), 32'(mdl_code()));
    check({name, "_valid"}, 32'(code_valid), 32'(mdl_ready));
    check({name, "_cnt"}, 32'(digit_cnt), 32'(mdl_digits.size()));
  endtask

  task automatic check_drained(input string name);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean press: held long enough for one event, released long enough to re-arm
  task automatic press(input int k, input int hold, input int gap);
    model_key(k);
    key_code = 4'(k);
    key_down = 1'b1;
    tick(hold);
    key_down = 1'b0;
    tick(gap);
  endtask

  // Glitch shorter than the debounce window: must produce no event
  task automatic noise(input int k, input int len);
    key_code = 4'(k);
    key_down = 1'b1;
    tick(len);
    key_down = 1'b0;
    tick(DEB + 1);
  endtask

  task automatic handshake_pulse();
    model_handshake();
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
  endtask

  // Monitor: every error pulse or accepted code is matched against the queue
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      if (entry_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_err: got unexpected entry_err pulse, required none");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_err) begin
            errors++;
            $display("FAIL mon_err: got entry_err pulse, required handshake of %0h", e.code);
          end else begin
            $display("ok   mon_err: entry_err pulse");
          end
        end
      end
      if (code_valid && code_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_hs: got unexpected handshake code %0h, required none", code);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err || (code !== e.code)) begin
            errors++;
            $display("FAIL mon_hs: got handshake code %0h, required %s %0h",
                     code, e.is_err ? "error pulse" : "code", e.code);
          end else begin
            $display("ok   mon_hs: handshake code %0h", code);
          end
        end
      end
    end
  end

  // Bounce patterns for the debounce scenario
  bit press_pat[7]   = '{1, 1, 0, 1, 1, 1, 1};
  bit release_pat[6] = '{0, 1, 0, 0, 0, 0};

  initial begin
    int r;
    int k;

    // Reset state
    tick(3);
    check("reset_code", 32'(code), 32'd0);
    check("reset_valid", 32'(code_valid), 32'd0);
    check("reset_cnt", 32'(digit_cnt), 32'd0);
    check("reset_err", 32'(entry_err), 32'd0);
    reset = 1'b1;
    tick(2);

    // 1: 4, 2, ENTER -> code 42 offered, held while code_ready is low
    press(4, 10, 10);
    press(2, 10, 10);
    press(10, 10, 10);
    check("t1_code_42", 32'(code), 32'h42);
    check_outputs("t1_ready");
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_outputs("t1_hold");
    end
    handshake_pulse();
    check("t1_valid_drop", 32'(code_valid), 32'd0);
    check_outputs("t1_after");
    check_drained("t1");

    // 2: bouncy press of 7 and bouncy release -> a single event
    model_key(7);
    key_code = 4'h7;
    foreach (press_pat[i]) begin
      key_down = press_pat[i];
      tick(1);
    end
    key_down = 1'b1;
    tick(8);
    foreach (release_pat[i]) begin
      key_down = release_pat[i];
      tick(1);
    end
    key_down = 1'b0;
    tick(8);
    check("t2_code_07", 32'(code), 32'h07);
    check_outputs("t2");
    press(11, 8, 8);
    check_outputs("t2_clear");

    // 3: early ENTER, overflow digit and CLEAR
    press(1, 8, 8);
    press(10, 8, 8);
    check_outputs("t3_early_enter");
    check_drained("t3_early_enter");
    press(2, 8, 8);
    press(3, 8, 8);
    check("t3_code_12", 32'(code), 32'h12);
    check_outputs("t3_overflow");
    check_drained("t3_overflow");
    press(11, 8, 8);
    check_outputs("t3_clear");

    // 4: key event in the same cycle as the handshake -> dropped with error
    press(5, 8, 8);
    press(5, 8, 8);
    press(10, 8, 8);
    check("t4_code_55", 32'(code), 32'h55);
    model_handshake();
    push_err();
    key_code = 4'h9;
    key_down = 1'b1;
    tick(DEB + 1);
    code_ready = 1'b1;
    tick(1);
    code_ready = 1'b0;
    tick(4);
    key_down = 1'b0;
    tick(10);
    check_outputs("t4_after");
    check_drained("t4");

    // 5: asynchronous reset mid-entry and mid-debounce
    press(5, 8, 8);
    check_outputs("t5_partial");
    key_code = 4'h6;
    key_down = 1'b1;
    tick(2);
    #2 reset = 1'b0;
    #1;
    mdl_digits.delete();
    mdl_ready = 1'b0;
    check_outputs("t5_in_reset");
    check("t5_err", 32'(entry_err), 32'd0);
    key_down = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
    press(3, 8, 8);
    check("t5_code_03", 32'(code), 32'h03);
    check_outputs("t5_fresh");
    press(11, 8, 8);

    // 6: inactivity with a partial entry
    press(8, 8, 8);
`ifdef KEYPAD_TIMEOUT_EN
    push_err();
    mdl_digits.delete();
    tick(TMO + 50);
    check_outputs("t6_timeout");
    check_drained("t6_timeout");
`else
    tick(10 * TMO);
    check("t6_code_08", 32'(code), 32'h08);
    check_outputs("t6_persist");
`endif
    press(11, 8, 8);

    // Randomized key stream with glitches and random consumer timing
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 10) begin
        noise($urandom_range(0, 15), $urandom_range(1, DEB));
      end else begin
        if (r < 55)      k = $urandom_range(0, 9);
        else if (r < 75) k = 10;
        else if (r < 85) k = 11;
        else             k = $urandom_range(12, 15);
        press(k, $urandom_range(DEB + 1, 12), $urandom_range(DEB + 1, 10));
      end
      if (mdl_ready && ($urandom_range(0, 1) == 1)) begin
        tick($urandom_range(0, 5));
        handshake_pulse();
      end
      check_outputs($sformatf("rand%0d", n));
    end

    tick(5);
    check_drained("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
